// File: rtl/router_1xn_pkt.sv
// router_1xn_pkt: 1xN packet router with per-channel FWFT FIFOs, header decode,
// parity check, and per-channel unread-data timeout flush.
// Optional store-and-forward mode: define PARITY_DROP_EN. Without it the router
// runs cut-through (bytes visible as soon as written, bad parity only flags err).

// One output channel: FIFO storage, read/visible pointers, timeout timer.
module router_chan #(
    parameter int DW      = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic          commit,
    input  logic          rollback,
    output logic          vld,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          full_on_wr,
    output logic          flush,
    output logic          soft_rst
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] FULL_PAT = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr, vptr, rptr_n;
    logic [TW-1:0] tmr;
    logic          wr_ok, pop;

`ifdef PARITY_DROP_EN
    // Readers only see data up to the last committed packet boundary.
    logic [AW:0] cptr;
    assign vptr = cptr;
`else
    logic unused_ctl;
    assign unused_ctl = commit | rollback;
    assign vptr = wptr;
`endif

    assign vld        = (rptr != vptr);
    assign dout       = vld ? mem[rptr[AW-1:0]] : '0;
    assign full       = ((wptr ^ rptr) == FULL_PAT);
    assign wr_ok      = wr && !full;
    assign pop        = rd_en && vld;
    assign rptr_n     = rptr + (AW + 1)'(pop);
    // Would the FIFO be full after a write this cycle? Independent of wr so the
    // FSM can use it without forming a combinational loop.
    assign full_on_wr = (((wptr + (AW + 1)'(1)) ^ rptr_n) == FULL_PAT);
    assign flush      = vld && !rd_en && (tmr == TW'(TIMEOUT - 1));

    // Storage write; contents need no reset since dout is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr[AW-1:0]] <= wdata;
    end

    // Pointer update; a flush empties the FIFO and beats any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
`ifdef PARITY_DROP_EN
            cptr <= '0;
`endif
        end else begin
            rptr <= rptr_n;
`ifdef PARITY_DROP_EN
            wptr <= rollback ? cptr : wptr + (AW + 1)'(wr_ok);
            if (commit)
                cptr <= wptr;
`else
            wptr <= wptr + (AW + 1)'(wr_ok);
`endif
        end
    end

    // Timeout: counts cycles of visible, unread data; any read or empty clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr      <= '0;
            soft_rst <= 1'b0;
        end else begin
            soft_rst <= flush;
            if (flush || rd_en || !vld)
                tmr <= '0;
            else
                tmr <= tmr + TW'(1);
        end
    end
endmodule

module router_1xn_pkt #(
    parameter int N       = 3,
    parameter int DW      = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pkt_vld,
    input  logic [DW-1:0]   din,
    output logic            busy,
    output logic            err,
    input  logic [N-1:0]    rd_en,
    output logic [N-1:0]    vld_out,
    output logic [N*DW-1:0] dout,
    output logic [N-1:0]    soft_rst
);
    localparam int ADDR_W = (N > 2) ? $clog2(N) : 1;
    localparam int LW     = DW - ADDR_W;

    typedef enum logic [2:0] {IDLE, LOAD, FULL_WAIT, CHECK, DROP} state_t;

    state_t              state, nxt;
    logic [LW-1:0]       cnt, cnt_n;
    logic [ADDR_W-1:0]   dest, dest_n, sel, hdr_addr;
    logic [LW-1:0]       hdr_len;
    logic [DW-1:0]       par, par_n;
    logic                bad, bad_n, err_n, busy_n;
    logic                accept, hdr_oob, wr_any, commit, rollback, stall;
    logic                sel_full, sel_fow, sel_flush;
    logic [N-1:0]        wr, full, full_on_wr, flush, ch_commit, ch_rollback;

    assign hdr_addr = din[ADDR_W-1:0];
    assign hdr_len  = din[DW-1:ADDR_W];
    assign hdr_oob  = ({1'b0, hdr_addr} >= (ADDR_W + 1)'(N));
    assign accept   = pkt_vld && !busy;
    // In IDLE the channel of interest is the one the incoming header names.
    assign sel      = (state == IDLE) ? hdr_addr : dest;

    // Per-channel FIFOs.
    for (genvar i = 0; i < N; i++) begin : g_ch
        router_chan #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr         (wr[i]),
            .wdata      (din),
            .rd_en      (rd_en[i]),
            .commit     (ch_commit[i]),
            .rollback   (ch_rollback[i]),
            .vld        (vld_out[i]),
            .dout       (dout[i*DW +: DW]),
            .full       (full[i]),
            .full_on_wr (full_on_wr[i]),
            .flush      (flush[i]),
            .soft_rst   (soft_rst[i])
        );
    end

    // Status of the selected channel; out-of-range addresses read as idle.
    always_comb begin
        sel_full  = 1'b0;
        sel_fow   = 1'b0;
        sel_flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel == ADDR_W'(i)) begin
                sel_full  = full[i];
                sel_fow   = full_on_wr[i];
                sel_flush = flush[i];
            end
        end
    end

    // Route FSM write/commit/rollback strobes to the selected channel.
    always_comb begin
        wr          = '0;
        ch_commit   = '0;
        ch_rollback = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == ADDR_W'(i)) begin
                wr[i]          = wr_any;
                ch_commit[i]   = commit;
                ch_rollback[i] = rollback;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        nxt      = state;
        cnt_n    = cnt;
        dest_n   = dest;
        par_n    = par;
        bad_n    = bad;
        err_n    = 1'b0;
        wr_any   = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        stall    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !sel_full) begin
                    cnt_n  = hdr_len;
                    dest_n = hdr_addr;
                    par_n  = din;
                    bad_n  = 1'b0;
                    if (hdr_oob) begin
                        nxt = DROP;
                    end else begin
                        wr_any = 1'b1;
                        nxt    = LOAD;
                        stall  = sel_fow;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_any = 1'b1;
                    if (cnt == '0) begin
                        nxt   = CHECK;
                        bad_n = (par != din);
                    end else begin
                        cnt_n = cnt - LW'(1);
                        par_n = par ^ din;
                        stall = sel_fow;
                    end
                end
            end
            FULL_WAIT: begin
                if (!sel_full)
                    nxt = LOAD;
            end
            CHECK: begin
                nxt   = IDLE;
                err_n = bad;
`ifdef PARITY_DROP_EN
                rollback = bad;
                commit   = !bad;
`endif
            end
            DROP: begin
                if (accept) begin
                    if (cnt == '0) begin
                        nxt   = IDLE;
                        err_n = 1'b1;
                    end else begin
                        cnt_n = cnt - LW'(1);
                    end
                end
            end
            default: nxt = IDLE;
        endcase

        // FIFO filled with bytes still to come.
        if (stall) begin
`ifdef PARITY_DROP_EN
            // Uncommitted packet can never drain: discard it and skip the rest.
            rollback = 1'b1;
            nxt      = DROP;
`else
            nxt = FULL_WAIT;
`endif
        end

        // Timeout flush of the channel being filled abandons the packet.
        if (sel_flush && (state == LOAD || state == FULL_WAIT || wr_any)) begin
            commit   = 1'b0;
            rollback = 1'b0;
            if (nxt == CHECK) begin
                nxt   = IDLE;
                err_n = 1'b1;
            end else begin
                nxt = DROP;
            end
        end

        busy_n = (nxt == FULL_WAIT) || (nxt == CHECK) ||
                 (state == IDLE && nxt == IDLE && pkt_vld && sel_full);
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            dest  <= '0;
            par   <= '0;
            bad   <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_n;
            dest  <= dest_n;
            par   <= par_n;
            bad   <= bad_n;
            busy  <= busy_n;
            err   <= err_n;
        end
    end
endmodule

// File: tb/tb_router_1xn_pkt.sv
// Directed bench for router_1xn_pkt (N=3, DW=8, DEPTH=16, TIMEOUT=30).
module tb_router_1xn_pkt;
    localparam int N = 3, DW = 8, DEPTH = 16, TIMEOUT = 30;
`ifdef PARITY_DROP_EN
    localparam bit SF = 1'b1;
`else
    localparam bit SF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, pkt_vld;
    logic [7:0]  din;
    logic        busy, err;
    logic [2:0]  rd_en, vld_out, soft_rst;
    logic [23:0] dout;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        pv;
        logic [7:0]  din;
        logic [2:0]  rd;
        logic        busy;
        logic        err;
        logic [2:0]  vld;
        logic [23:0] dout;
    } vec_t;
    vec_t tbl[$];

    router_1xn_pkt #(.N(N), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .din(din), .busy(busy), .err(err),
        .rd_en(rd_en), .vld_out(vld_out), .dout(dout), .soft_rst(soft_rst)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [7:0] d, input logic [2:0] rd,
                       input logic b, input logic e, input logic [2:0] v, input logic [23:0] o);
        vec_t t;
        t.pv = pv; t.din = d; t.rd = rd; t.busy = b; t.err = e; t.vld = v; t.dout = o;
        tbl.push_back(t);
    endtask

    task automatic send(input logic [7:0] b);
        pkt_vld = 1'b1;
        din     = b;
        step();
        pkt_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  cv;
        logic [23:0] ch;
        int          r;
        cv = SF ? 3'b000 : 3'b010;
        ch = SF ? 24'h0 : 24'h000D00;
        r  = SF ? 3 : 0;

        // Good packet to ch1: hdr 0D (addr1,len3), 11 22 33, parity 0D
        add(1, 8'h0D, 0, 0, 0, cv, ch);
        add(1, 8'h11, 0, 0, 0, cv, ch);
        add(1, 8'h22, 0, 0, 0, cv, ch);
        add(1, 8'h33, 0, 0, 0, cv, ch);
        add(1, 8'h0D, 0, 1, 0, cv, ch);
        add(0, 8'h00, 0, 0, 0, 3'b010, 24'h000D00);
        add(0, 8'h00, 0, 0, 0, 3'b010, 24'h000D00);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h001100);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h002200);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h003300);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h000D00);
        add(0, 8'h00, 3'b010, 0, 0, 3'b000, 24'h000000);
        // Same packet, bad parity EE
        add(1, 8'h0D, 0, 0, 0, cv, ch);
        add(1, 8'h11, 0, 0, 0, cv, ch);
        add(1, 8'h22, 0, 0, 0, cv, ch);
        add(1, 8'h33, 0, 0, 0, cv, ch);
        add(1, 8'hEE, 0, 1, 0, cv, ch);
        add(0, 8'h00, 0, 0, 1, cv, ch);
        add(0, 8'h00, 0, 0, 0, cv, ch);
        add(0, 8'h00, 3'b010, 0, 0, cv, SF ? 24'h0 : 24'h001100);
        add(0, 8'h00, 3'b010, 0, 0, cv, SF ? 24'h0 : 24'h002200);
        add(0, 8'h00, 3'b010, 0, 0, cv, SF ? 24'h0 : 24'h003300);
        add(0, 8'h00, 3'b010, 0, 0, cv, SF ? 24'h0 : 24'h00EE00);
        add(0, 8'h00, 3'b010, 0, 0, 3'b000, 24'h000000);
        // addr 3 (out of range), len 2: dropped, err after 3 more bytes
        add(1, 8'h0B, 0, 0, 0, 3'b000, 24'h0);
        add(1, 8'hAA, 0, 0, 0, 3'b000, 24'h0);
        add(1, 8'hBB, 0, 0, 0, 3'b000, 24'h0);
        add(1, 8'hCC, 0, 0, 1, 3'b000, 24'h0);
        // next packet accepted normally
        add(1, 8'h0D, 0, 0, 0, cv, ch);
        add(1, 8'h11, 0, 0, 0, cv, ch);
        add(1, 8'h22, 0, 0, 0, cv, ch);
        add(1, 8'h33, 0, 0, 0, cv, ch);
        add(1, 8'h0D, 0, 1, 0, cv, ch);
        add(0, 8'h00, 0, 0, 0, 3'b010, 24'h000D00);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h001100);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h002200);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h003300);
        add(0, 8'h00, 3'b010, 0, 0, 3'b010, 24'h000D00);
        add(0, 8'h00, 3'b010, 0, 0, 3'b000, 24'h000000);

        // Reset state
        rst = 1'b1; pkt_vld = 1'b0; din = '0; rd_en = '0;
        step(); step();
        rst = 1'b0;
        chk("reset busy", 32'(busy), 0);
        chk("reset err", 32'(err), 0);
        chk("reset vld_out", 32'(vld_out), 0);
        chk("reset dout", 32'(dout), 0);
        chk("reset soft_rst", 32'(soft_rst), 0);

        // Table vectors
        for (int i = 0; i < tbl.size(); i++) begin
            pkt_vld = tbl[i].pv;
            din     = tbl[i].din;
            rd_en   = tbl[i].rd;
            step();
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d err", i), 32'(err), 32'(tbl[i].err));
            chk($sformatf("v%0d vld_out", i), 32'(vld_out), 32'(tbl[i].vld));
            chk($sformatf("v%0d dout", i), 32'(dout), 32'(tbl[i].dout));
            chk($sformatf("v%0d soft_rst", i), 32'(soft_rst), 0);
        end
        pkt_vld = 1'b0; rd_en = '0;

`ifndef PARITY_DROP_EN
        // Back-pressure: len 20 to ch0, nothing read
        pkt_vld = 1'b1; din = 8'h50;
        step();
        for (int i = 1; i <= 15; i++) begin
            din = 8'(i);
            step();
            if (i == 14) chk("bp busy before full", 32'(busy), 0);
        end
        chk("bp busy after 16 writes", 32'(busy), 1);
        chk("bp vld0", 32'(vld_out), 32'b001);
        chk("bp head", 32'(dout[7:0]), 32'h50);
        din = 8'd16;
        step();
        chk("bp busy held", 32'(busy), 1);
        rd_en = 3'b001;
        step();
        rd_en = '0;
        chk("bp busy after pop", 32'(busy), 1);
        chk("bp head after pop", 32'(dout[7:0]), 32'h01);
        step();
        chk("bp busy released", 32'(busy), 0);
        step();
        chk("bp next byte fills", 32'(busy), 1);
        pkt_vld = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("bp reset vld", 32'(vld_out), 0);
`endif

        // Timeout flush on ch2: hdr 06 (addr2,len1), 5A, parity 5C
        send(8'h06); send(8'h5A); send(8'h5C);
        for (int k = 3; k <= r + 29; k++) step();
        chk("to vld before flush", 32'(vld_out[2]), 1);
        chk("to no early soft_rst", 32'(soft_rst), 0);
        step();
        chk("to soft_rst pulse", 32'(soft_rst), 32'b100);
        chk("to flushed vld", 32'(vld_out[2]), 0);
        chk("to flushed dout", 32'(dout[23:16]), 0);
        step();
        chk("to soft_rst one cycle", 32'(soft_rst), 0);

        // Read at cycle 29 prevents flush
        send(8'h06); send(8'h5A); send(8'h5C);
        for (int k = 3; k <= r + 29; k++) step();
        rd_en = 3'b100;
        step();
        rd_en = '0;
        chk("tr no soft_rst", 32'(soft_rst), 0);
        chk("tr vld kept", 32'(vld_out[2]), 1);
        chk("tr head after pop", 32'(dout[23:16]), 32'h5A);
        step(); step(); step();
        chk("tr still no soft_rst", 32'(soft_rst), 0);
        rd_en = 3'b100;
        step(); step();
        rd_en = '0;
        chk("tr drained", 32'(vld_out), 0);

        // Reset mid-payload, then a fresh packet
        send(8'h0D); send(8'h99);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr busy", 32'(busy), 0);
        chk("mr err", 32'(err), 0);
        chk("mr vld_out", 32'(vld_out), 0);
        chk("mr dout", 32'(dout), 0);
        chk("mr soft_rst", 32'(soft_rst), 0);
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        step(); step();
        chk("mr new vld", 32'(vld_out), 32'b010);
        chk("mr new head", 32'(dout), 32'h000D00);
        chk("mr err clean", 32'(err), 0);
        rd_en = 3'b010;
        step();
        rd_en = '0;
        chk("mr second byte", 32'(dout), 32'h001100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
